decimal_multiple_accumulator: RTL and testbench

- Sequential consumer of the X1..X5 multiples produced by the multiple-generation stage.
- Walks the BCD multiplier Y one digit per step, least-significant digit first.
- For each digit, selects one or two 4221-coded multiples, recodes them to BCD 8421 and accumulates them with a decimal adder.
- Returns the full 2N-digit BCD product.
- Closes the loop from 4221 multiples back to an 8421 product for the parallel decimal multiplier datapath.

---
 rtl/decimal_multiple_accumulator_if.sv | 38 +++
 rtl/decimal_multiple_accumulator.sv | 190 +++++++++++++++++++
 tb/tb_decimal_multiple_accumulator.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/decimal_multiple_accumulator_if.sv
// Handshake and data bundle between a multiplier control/source block and
// the decimal multiple accumulator.
//   start          begin a multiplication (sampled only while the accumulator is idle)
//   y_bcd          multiplier Y, BCD 8421, N_DIGITS digits
//   x1..x5_4221    multiples 1X..5X, 4221 coded, N_DIGITS+1 digits each
//   busy           accumulation in progress
//   done           one-cycle pulse when p_bcd is valid
//   err            raised with done when any Y digit exceeded 9
//   p_bcd          2*N_DIGITS-digit BCD product
interface decimal_multiple_accumulator_if #(
  parameter int unsigned N_DIGITS = 4
);
  localparam int unsigned YW = 4 * N_DIGITS;
  localparam int unsigned XW = 4 * (N_DIGITS + 1);
  localparam int unsigned PW = 8 * N_DIGITS;

  logic          start;
  logic [YW-1:0] y_bcd;
  logic [XW-1:0] x1_4221;
  logic [XW-1:0] x2_4221;
  logic [XW-1:0] x3_4221;
  logic [XW-1:0] x4_4221;
  logic [XW-1:0] x5_4221;
  logic          busy;
  logic          done;
  logic          err;
  logic [PW-1:0] p_bcd;

  modport master (
    output start, y_bcd, x1_4221, x2_4221, x3_4221, x4_4221, x5_4221,
    input  busy, done, err, p_bcd
  );

  modport slave (
    input  start, y_bcd, x1_4221, x2_4221, x3_4221, x4_4221, x5_4221,
    output busy, done, err, p_bcd
  );
endinterface

// File: rtl/decimal_multiple_accumulator.sv
// Sequential decimal multiple accumulator. Walks the BCD multiplier one digit
// per step (LSD first), adds the selected 4221 multiples (recoded to 8421 at
// capture) into a decimal accumulator and shifts one digit out per step,
// producing the full 2*N_DIGITS-digit BCD product.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   slave side of decimal_multiple_accumulator_if (start, y_bcd,
//         x1..x5_4221 in; busy, done, err, p_bcd out)
// Build option: define DECMUL_FAST_DIGIT_EN to skip the X5 cycle for digits
// 0..4 (and invalid digits), giving data-dependent latency.
module decimal_multiple_accumulator #(
  parameter int unsigned N_DIGITS = 4
) (
  input logic                          clk,
  input logic                          rst,
  decimal_multiple_accumulator_if.slave bus
);
  localparam int unsigned YW = 4 * N_DIGITS;
  localparam int unsigned HW = 4 * (N_DIGITS + 1);
  localparam int unsigned LW = 4 * N_DIGITS;
  localparam int unsigned PW = 8 * N_DIGITS;
  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, ADD_A, ADD_B, DONE} state_t;

  state_t             state, state_n;
  logic [YW-1:0]      y_q;
  logic [4:0][HW-1:0] x_q;      // x_q[k] holds multiple (k+1)X in 8421
  logic [HW-1:0]      acc_hi;
  logic [LW-1:0]      acc_lo;
  logic [IW-1:0]      idx;
  logic               err_flag;
  logic               busy_q, done_q, err_q;
  logic [PW-1:0]      p_q;

  logic [3:0]         digit_c, digit_v_c, low_sel_c;
  logic               digit_ok_c, hi_sel_c, last_c;
  logic [HW-1:0]      addend_c, sum_c;

  // 4221 -> 8421 per digit: 4*b3 + 2*b2 + 2*b1 + b0
  function automatic logic [HW-1:0] recode_4221(input logic [HW-1:0] v);
    logic [HW-1:0] r;
    logic [3:0]    c;
    r = '0;
    for (int i = 0; i < int'(N_DIGITS + 1); i++) begin
      c = v[4*i +: 4];
      r[4*i +: 4] = {1'b0, c[3], 2'b00} + {2'b00, c[2], 1'b0}
                  + {2'b00, c[1], 1'b0} + {3'b000, c[0]};
    end
    return r;
  endfunction

  // Decimal add with per-digit carry; the final carry is provably zero.
  function automatic logic [HW-1:0] bcd_add(input logic [HW-1:0] a, input logic [HW-1:0] b);
    logic [HW-1:0] s;
    logic [4:0]    t;
    logic          cy;
    s  = '0;
    cy = 1'b0;
    for (int i = 0; i < int'(N_DIGITS + 1); i++) begin
      t = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, cy};
      if (t > 5'd9) begin
        t  = t - 5'd10;
        cy = 1'b1;
      end else begin
        cy = 1'b0;
      end
      s[4*i +: 4] = t[3:0];
    end
    return s;
  endfunction

`ifdef DECMUL_FAST_DIGIT_EN
  // Digits with no X5 contribution need no ADD_A cycle.
  function automatic logic skip_a(input logic [3:0] d);
    return (d < 4'd5) || (d > 4'd9);
  endfunction
`endif

  // Digit decode and multiple selection for the current step
  always_comb begin
    digit_c    = y_q[{idx, 2'b00} +: 4];
    digit_ok_c = (digit_c <= 4'd9);
    digit_v_c  = digit_ok_c ? digit_c : 4'd0;
    hi_sel_c   = (digit_v_c >= 4'd5);
    low_sel_c  = hi_sel_c ? (digit_v_c - 4'd5) : digit_v_c;
    last_c     = (idx == IW'(N_DIGITS - 1));
    addend_c   = '0;
    if (state == ADD_B) begin
      case (low_sel_c)
        4'd1:    addend_c = x_q[0];
        4'd2:    addend_c = x_q[1];
        4'd3:    addend_c = x_q[2];
        4'd4:    addend_c = x_q[3];
        default: addend_c = '0;
      endcase
    end else if (hi_sel_c) begin
      addend_c = x_q[4];
    end
    sum_c = bcd_add(acc_hi, addend_c);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
`ifdef DECMUL_FAST_DIGIT_EN
          state_n = skip_a(bus.y_bcd[3:0]) ? ADD_B : ADD_A;
`else
          state_n = ADD_A;
`endif
        end
      end
      ADD_A: state_n = ADD_B;
      ADD_B: begin
        if (last_c) begin
          state_n = DONE;
        end else begin
`ifdef DECMUL_FAST_DIGIT_EN
          state_n = skip_a(y_q[{IW'(idx + IW'(1)), 2'b00} +: 4]) ? ADD_B : ADD_A;
`else
          state_n = ADD_A;
`endif
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, accumulation, digit shift and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q      <= '0;
      x_q      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      idx      <= '0;
      err_flag <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      p_q      <= '0;
    end else begin
      busy_q <= (state_n == ADD_A) || (state_n == ADD_B);
      done_q <= (state == DONE);
      err_q  <= (state == DONE) && err_flag;
      case (state)
        IDLE: begin
          if (bus.start) begin
            y_q      <= bus.y_bcd;
            x_q[0]   <= recode_4221(bus.x1_4221);
            x_q[1]   <= recode_4221(bus.x2_4221);
            x_q[2]   <= recode_4221(bus.x3_4221);
            x_q[3]   <= recode_4221(bus.x4_4221);
            x_q[4]   <= recode_4221(bus.x5_4221);
            acc_hi   <= '0;
            acc_lo   <= '0;
            idx      <= '0;
            err_flag <= 1'b0;
          end
        end
        ADD_A: acc_hi <= sum_c;
        ADD_B: begin
          // LSD of the new sum retires into acc_lo
          acc_hi <= {4'b0000, sum_c[HW-1:4]};
          acc_lo <= {sum_c[3:0], acc_lo[LW-1:4]};
          idx    <= idx + IW'(1);
          if (!digit_ok_c) err_flag <= 1'b1;
        end
        DONE:    p_q <= {acc_hi[LW-1:0], acc_lo};
        default: ;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.p_bcd = p_q;
endmodule

// File: tb/tb_decimal_multiple_accumulator.sv
// Directed bench for decimal_multiple_accumulator: hand-computed products,
// latency/busy/err timing, reset abort and ignored start pulses.
module tb_decimal_multiple_accumulator;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  decimal_multiple_accumulator_if #(.N_DIGITS(N)) bus ();

  decimal_multiple_accumulator #(.N_DIGITS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal value -> 5-digit 4221 code; alt picks the other legal code words.
  function automatic logic [19:0] enc4221(input int unsigned v, input bit alt);
    logic [19:0]  r;
    int unsigned  t;
    int unsigned  d;
    logic [3:0]   c;
    r = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      d = t % 10;
      t = t / 10;
      case (d)
        0: c = 4'b0000;
        1: c = 4'b0001;
        2: c = alt ? 4'b0100 : 4'b0010;
        3: c = alt ? 4'b0101 : 4'b0011;
        4: c = alt ? 4'b0110 : 4'b1000;
        5: c = alt ? 4'b0111 : 4'b1001;
        6: c = alt ? 4'b1100 : 4'b1010;
        7: c = alt ? 4'b1101 : 4'b1011;
        8: c = 4'b1110;
        default: c = 4'b1111;
      endcase
      r[4*i +: 4] = c;
    end
    return r;
  endfunction

  function automatic int exp_latency(input logic [15:0] y);
    int         lat;
    logic [3:0] d;
    lat = 1;
    for (int i = 0; i < 4; i++) begin
      d = y[4*i +: 4];
`ifdef DECMUL_FAST_DIGIT_EN
      lat += (d >= 4'd5 && d <= 4'd9) ? 2 : 1;
`else
      lat += 2;
      d = 4'd0;
`endif
    end
    return lat;
  endfunction

  task automatic drive_op(input int unsigned x, input logic [15:0] y, input bit alt);
    bus.y_bcd   = y;
    bus.x1_4221 = enc4221(x * 1, alt);
    bus.x2_4221 = enc4221(x * 2, alt);
    bus.x3_4221 = enc4221(x * 3, alt);
    bus.x4_4221 = enc4221(x * 4, alt);
    bus.x5_4221 = enc4221(x * 5, alt);
    bus.start   = 1'b1;
  endtask

  task automatic scramble();
    bus.y_bcd   = 16'($urandom);
    bus.x1_4221 = 20'($urandom);
    bus.x2_4221 = 20'($urandom);
    bus.x3_4221 = 20'($urandom);
    bus.x4_4221 = 20'($urandom);
    bus.x5_4221 = 20'($urandom);
  endtask

  // One multiplication; hold keeps start high through busy and the DONE cycle.
  task automatic run_op(input string tag, input int unsigned x, input logic [15:0] y,
                        input bit alt, input logic [31:0] exp_p, input bit exp_err,
                        input bit hold);
    int cyc;
    int nbusy;
    int lat;
    int extra;
    bit got;
    lat = exp_latency(y);
    @(negedge clk);
    drive_op(x, y, alt);
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    scramble();
    nbusy = int'(bus.busy);
    cyc   = 0;
    got   = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) got = 1'b1;
      else          nbusy += int'(bus.busy);
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    chk({tag, "_p"}, 64'(bus.p_bcd), 64'(exp_p));
    chk({tag, "_err"}, 64'(bus.err), 64'(exp_err));
    chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(lat - 1));
    @(posedge clk);
    #1;
    chk({tag, "_done_fall"}, 64'(bus.done), 64'd0);
    chk({tag, "_err_fall"}, 64'(bus.err), 64'd0);
    chk({tag, "_p_hold"}, 64'(bus.p_bcd), 64'(exp_p));
    if (hold) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk);
        #1;
        extra += int'(bus.done) + int'(bus.busy);
      end
      chk({tag, "_no_restart"}, 64'(extra), 64'd0);
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.y_bcd   = '0;
    bus.x1_4221 = '0;
    bus.x2_4221 = '0;
    bus.x3_4221 = '0;
    bus.x4_4221 = '0;
    bus.x5_4221 = '0;
    #12;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err",  64'(bus.err),  64'd0);
    chk("rst_p",    64'(bus.p_bcd), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("y0",     1234, 16'h0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    run_op("m5678",  5678, 16'h1234, 1'b1, 32'h0700_6652, 1'b0, 1'b0);
    run_op("m9999",  9999, 16'h9999, 1'b0, 32'h9998_0001, 1'b0, 1'b0);
    run_op("m0001",  1,    16'h0001, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
    run_op("bad_y",  2,    16'h12A4, 1'b0, 32'h0000_2408, 1'b1, 1'b0);

    // Reset in the middle of an operation
    @(negedge clk);
    drive_op(5678, 16'h1234, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_err",  64'(bus.err),  64'd0);
    chk("abort_p",    64'(bus.p_bcd), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("m0003", 3,    16'h0003, 1'b0, 32'h0000_0009, 1'b0, 1'b0);
    run_op("hold",  1111, 16'h1234, 1'b1, 32'h0137_0974, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
